// File: rtl/astar_pkg.sv
// Shared A* definitions: grid/list sizing, search-side state encodings and the
// node coordinate pair used by the open list, closed list and search FSM.
package astar_pkg;

  localparam int COORD_W = 8;
  localparam int DEPTH   = 400;
  localparam int IDX_W   = 9;

  typedef enum logic [7:0] {
    WIPE  = 8'h01,
    READY = 8'h02
  } cl_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } node_t;

endpackage

// File: rtl/closed_list_ram.sv
// Closed-list storage: one write port, one registered read port, no reset on
// the array so it maps onto block RAM.
module closed_list_ram #(
  parameter int DEPTH = 400,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/closed_list_writer.sv
// A* closed list: append-only insert port, registered random-access read port,
// and a full-array wipe after reset or Clear so stale nodes never match.
module closed_list_writer
  import astar_pkg::*;
#(
  parameter int DEPTH   = astar_pkg::DEPTH,
  parameter int COORD_W = astar_pkg::COORD_W,
  parameter int IDX_W   = astar_pkg::IDX_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Ins_valid,
  input  logic [COORD_W-1:0] Ins_x,
  input  logic [COORD_W-1:0] Ins_y,
  output logic               Ins_ready,
  output logic               Ins_ack,
  output logic [IDX_W-1:0]   Ins_index,
  input  logic               Rd_en,
  input  logic [IDX_W-1:0]   Rd_index,
  output logic [COORD_W-1:0] Rd_x,
  output logic [COORD_W-1:0] Rd_y,
  output logic               Rd_valid,
  output logic [IDX_W-1:0]   Count,
  output logic               Full,
  output logic               Busy,
  output logic               Overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] FULL_CNT  = IDX_W'(DEPTH);

  cl_state_e            state_q, state_d;
  logic [IDX_W-1:0]     wipe_ptr_q, wipe_ptr_d;
  logic [IDX_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     ins_index_q, ins_index_d;
  logic                 ins_ack_q, ins_ack_d;
  logic                 ovf_q, ovf_d;
  logic                 rd_valid_q, rd_valid_d;

  logic                 full;
  logic                 accept;
  logic                 ram_we;
  logic                 ram_re;
  logic [IDX_W-1:0]     ram_waddr;
  logic [2*COORD_W-1:0] ram_wdata;
  logic [2*COORD_W-1:0] ram_rdata;

  assign full      = (count_q == FULL_CNT);
  assign Ins_ready = (state_q == READY) && !full && !Clear;
  assign accept    = Ins_valid && Ins_ready;

  always_comb begin
    state_d     = state_q;
    wipe_ptr_d  = wipe_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    ins_ack_d   = accept;
    ins_index_d = ins_index_q;
    ram_we      = 1'b0;
    ram_waddr   = count_q;
    ram_wdata   = {Ins_x, Ins_y};
    case (state_q)
      WIPE: begin
        ram_we    = 1'b1;
        ram_waddr = wipe_ptr_q;
        ram_wdata = '0;
        if (Clear) begin
          wipe_ptr_d = '0;
          ovf_d      = 1'b0;
        end else if (wipe_ptr_q == LAST_IDX) begin
          state_d    = READY;
          wipe_ptr_d = '0;
        end else begin
          wipe_ptr_d = wipe_ptr_q + 1'b1;
        end
      end
      READY: begin
        if (Clear) begin
          state_d    = WIPE;
          wipe_ptr_d = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end else if (accept) begin
          ram_we      = 1'b1;
          count_d     = count_q + 1'b1;
          ins_index_d = count_q;
        end else if (Ins_valid && full) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = WIPE;
    endcase
  end

  // Validity uses the pre-edge Count, so a read racing an insert to the same slot is rejected.
  always_comb begin
    rd_valid_d = rd_valid_q;
    if (Rd_en) rd_valid_d = (state_q == READY) && (Rd_index < count_q);
  end

  assign ram_re = Rd_en && (Rd_index < FULL_CNT);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= WIPE;
      wipe_ptr_q  <= '0;
      count_q     <= '0;
      ins_index_q <= '0;
      ins_ack_q   <= 1'b0;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wipe_ptr_q  <= wipe_ptr_d;
      count_q     <= count_d;
      ins_index_q <= ins_index_d;
      ins_ack_q   <= ins_ack_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  closed_list_ram #(
    .DEPTH (DEPTH),
    .AW    (IDX_W),
    .DW    (2 * COORD_W)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (Rd_index),
    .rdata_o (ram_rdata)
  );

  // Read data is forced to zero whenever the registered valid is low.
  assign Rd_x      = rd_valid_q ? ram_rdata[2*COORD_W-1:COORD_W] : '0;
  assign Rd_y      = rd_valid_q ? ram_rdata[COORD_W-1:0] : '0;
  assign Rd_valid  = rd_valid_q;
  assign Ins_ack   = ins_ack_q;
  assign Ins_index = ins_index_q;
  assign Count     = count_q;
  assign Full      = full;
  assign Busy      = (state_q == WIPE);
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_closed_list_writer.sv
// Scoreboard bench for closed_list_writer: a list-level reference model queues
// expected acks and read results, and a monitor checks them as the DUT responds.
module tb_closed_list_writer;
  import astar_pkg::*;

  localparam int D = 400;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Clear = 1'b0;
  logic       Ins_valid = 1'b0;
  logic [7:0] Ins_x = '0;
  logic [7:0] Ins_y = '0;
  logic       Rd_en = 1'b0;
  logic [8:0] Rd_index = '0;
  logic       Ins_ready, Ins_ack, Rd_valid, Full, Busy, Overflow;
  logic [8:0] Ins_index, Count;
  logic [7:0] Rd_x, Rd_y;

  closed_list_writer dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear),
    .Ins_valid(Ins_valid), .Ins_x(Ins_x), .Ins_y(Ins_y),
    .Ins_ready(Ins_ready), .Ins_ack(Ins_ack), .Ins_index(Ins_index),
    .Rd_en(Rd_en), .Rd_index(Rd_index), .Rd_x(Rd_x), .Rd_y(Rd_y),
    .Rd_valid(Rd_valid), .Count(Count), .Full(Full), .Busy(Busy),
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model: list contents, live count, wipe cycles still to run.
  node_t        m_mem [D];
  int           m_cnt = 0;
  int           m_wipe_left = D;
  bit           m_ovf = 1'b0;
  int           ack_q [$];
  logic [16:0]  rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic        ren, rok, exp_ack;
    int          idx;
    logic [16:0] e;
    forever begin
      @(posedge Clk);
      ren = Rd_en;
      rok = Reset;
      #1;
      if (rok && Reset) begin
        exp_ack = (ack_q.size() != 0);
        check("ins_ack", Ins_ack, exp_ack);
        if (exp_ack) begin
          idx = ack_q.pop_front();
          if (Ins_ack) check("ins_index", Ins_index, idx);
        end
        if (ren && rd_q.size() != 0) begin
          e = rd_q.pop_front();
          check("rd_valid", Rd_valid, e[16]);
          check("rd_data", {Rd_x, Rd_y}, e[15:0]);
        end
        check("count", Count, m_cnt);
        check("full", Full, m_cnt == D);
        check("busy", Busy, m_wipe_left != 0);
        check("overflow", Overflow, m_ovf);
        check("ins_ready", Ins_ready, (m_wipe_left == 0) && (m_cnt < D) && !Clear);
      end
    end
  end

  // One clock of stimulus, entered and left just after a falling edge.
  task automatic step(input bit iv, input logic [7:0] x, input logic [7:0] y,
                      input bit re, input logic [8:0] ri, input bit clr);
    bit rdy;
    Ins_valid = iv; Ins_x = x; Ins_y = y;
    Rd_en = re; Rd_index = ri; Clear = clr;
    rdy = (m_wipe_left == 0);
    if (re) begin
      if (rdy && int'(ri) < m_cnt) rd_q.push_back({1'b1, m_mem[ri]});
      else rd_q.push_back(17'h0);
    end
    @(posedge Clk);
    if (clr) begin
      m_cnt = 0; m_ovf = 1'b0; m_wipe_left = D;
    end else if (!rdy) begin
      m_wipe_left--;
    end else if (iv && m_cnt < D) begin
      ack_q.push_back(m_cnt);
      m_mem[m_cnt] = {x, y};
      m_cnt++;
    end else if (iv) begin
      m_ovf = 1'b1;
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h0, 8'h0, 1'b0, 9'h0, 1'b0);
  endtask

  task automatic apply_reset();
    #2;
    Reset = 1'b0;
    #1;
    check("rst_count", Count, 0);
    check("rst_ins_ack", Ins_ack, 0);
    check("rst_ins_index", Ins_index, 0);
    check("rst_rd_xy", {Rd_x, Rd_y}, 0);
    check("rst_rd_valid", Rd_valid, 0);
    check("rst_overflow", Overflow, 0);
    check("rst_full", Full, 0);
    check("rst_busy", Busy, 1);
    check("rst_ins_ready", Ins_ready, 0);
    m_cnt = 0; m_ovf = 1'b0; m_wipe_left = D;
    ack_q.delete(); rd_q.delete();
    Ins_valid = 1'b0; Rd_en = 1'b0; Clear = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  // Counts the cycles Busy stays high while reads (and optionally inserts) are attempted.
  task automatic wipe_wait(input string name, input bit iv);
    int n;
    n = 0;
    while (Busy && n < 1000) begin
      step(iv, 8'($urandom), 8'($urandom), 1'b1, 9'($urandom_range(0, 511)), 1'b0);
      n++;
    end
    check(name, n, D);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c;
    @(negedge Clk);
    apply_reset();
    wipe_wait("wipe_len_after_reset", 1'b1);

    step(1'b1, 8'd3, 8'd5, 1'b0, 9'd0, 1'b0);
    step(1'b1, 8'd7, 8'd2, 1'b0, 9'd0, 1'b0);
    step(1'b1, 8'd0, 8'd0, 1'b0, 9'd0, 1'b0);
    check("count_after_three", Count, 3);
    step(1'b0, 8'd0, 8'd0, 1'b1, 9'd1, 1'b0);
    check("read_idx1_xy", {Rd_x, Rd_y}, {8'd7, 8'd2});
    step(1'b0, 8'd0, 8'd0, 1'b1, 9'd3, 1'b0);
    check("read_idx3_valid", Rd_valid, 0);

    for (int i = 3; i < D; i++) step(1'b1, 8'(i % 256), 8'(i / 256), 1'b0, 9'd0, 1'b0);
    check("full_after_400", Full, 1);
    step(1'b1, 8'd1, 8'd1, 1'b1, 9'd399, 1'b0);
    check("overflow_set", Overflow, 1);
    check("count_saturated", Count, D);
    check("read_idx399_xy", {Rd_x, Rd_y}, {8'd143, 8'd1});
    repeat (3) step(1'b0, 8'd0, 8'd0, 1'b1, 9'($urandom_range(0, 399)), 1'b0);

    step(1'b0, 8'd0, 8'd0, 1'b0, 9'd0, 1'b1);
    wipe_wait("wipe_len_after_clear_full", 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 9'd0, 1'b0);
    step(1'b1, 8'd4, 8'd4, 1'b0, 9'd0, 1'b1);
    check("clear_count", Count, 0);
    check("clear_ack", Ins_ack, 0);
    wipe_wait("wipe_len_after_clear", 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b1, 9'd0, 1'b0);
    check("read_idx0_after_clear", Rd_valid, 0);

    step(1'b0, 8'd0, 8'd0, 1'b0, 9'd0, 1'b1);
    repeat (200) idle();
    apply_reset();
    wipe_wait("wipe_len_reset_midwipe", 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 9'd0, 1'b0);
    apply_reset();
    wipe_wait("wipe_len_reset_midinsert", 1'b0);

    step(1'b1, 8'd1, 8'd2, 1'b0, 9'd0, 1'b0);
    step(1'b1, 8'd3, 8'd4, 1'b0, 9'd0, 1'b0);
    step(1'b1, 8'd9, 8'd9, 1'b1, 9'd2, 1'b0);
    check("rbw_read_valid", Rd_valid, 0);
    step(1'b0, 8'd0, 8'd0, 1'b1, 9'd2, 1'b0);
    check("rbw_next_xy", {Rd_x, Rd_y}, {8'd9, 8'd9});
    check("rbw_next_valid", Rd_valid, 1);

    for (int i = 0; i < 3000; i++) begin
      c = m_cnt + 3;
      step(($urandom % 10) < 7, 8'($urandom), 8'($urandom), ($urandom % 3) != 0,
           9'($urandom_range(0, (c > 511) ? 511 : c)), ($urandom % 700) == 0);
    end
    repeat (2) idle();
    check("ack_queue_drained", ack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/closed_list_writer.md
Name: closed_list_writer

Overview:
- Owns the A* closed-list storage: 400 entries of (x,y) node coordinates, with an append-only insert port used by the expansion FSM.
- Exposes a registered random-access read port; the linear closed-list search walks indices 0..Count-1 through it.
- Wipes the storage on reset and on Clear, so stale nodes from a previous path search can never match.

Parameters:
- DEPTH, 400, number of closed-list entries.
- COORD_W, 8, width of each x and y coordinate.
- IDX_W, 9, index and count width; must satisfy 2^IDX_W > DEPTH.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- Clear  in  1  single-cycle request to empty and wipe the list.
- Ins_valid  in  1  insert request.
- Ins_x  in  COORD_W  node x to insert.
- Ins_y  in  COORD_W  node y to insert.
- Ins_ready  out  1  block can accept an insert this cycle.
- Ins_ack  out  1  one-cycle pulse after each accepted insert.
- Ins_index  out  IDX_W  slot written by the acknowledged insert.
- Rd_en  in  1  read request.
- Rd_index  in  IDX_W  entry to read.
- Rd_x  out  COORD_W  read data x.
- Rd_y  out  COORD_W  read data y.
- Rd_valid  out  1  read data is a live entry.
- Count  out  IDX_W  number of live entries.
- Full  out  1  Count == DEPTH.
- Busy  out  1  wipe in progress.
- Overflow  out  1  sticky: an insert was attempted while Full.

Behaviour:
- Reset (Reset=0), applied asynchronously to all outputs and state:
  - Count=0, Ins_ack=0, Ins_index=0, Rd_x=0, Rd_y=0, Rd_valid=0, Overflow=0, Full=0.
  - Internal wipe pointer=0, state=WIPE, so Busy=1 and Ins_ready=0.
  - Memory contents are not reset asynchronously; the WIPE state clears them.
- States:
  - WIPE: writes (0,0) to entry wipe_ptr and increments wipe_ptr each cycle. When wipe_ptr==DEPTH-1 is written, go to READY next cycle. Takes exactly DEPTH cycles.
  - READY: normal operation. Busy=0.
- Ins_ready = (state==READY) && !Full && !Clear. This is combinational from state, Count and Clear.
- Accepted insert (Ins_valid && Ins_ready):
  - Writes (Ins_x,Ins_y) into entry Count on that edge.
  - Next cycle: Count+1, Ins_ack=1, Ins_index = old Count.
  - Back-to-back inserts are allowed every cycle.
- Duplicates are not filtered; the caller searches before inserting.
- Full = (Count==DEPTH). When Full, Ins_ready=0. Ins_valid=1 in READY while Full sets Overflow=1, which is cleared only by reset or Clear. Count saturates at DEPTH and never wraps.
- Clear in READY:
  - Next cycle: Count=0, Overflow=0, Ins_ack=0, state=WIPE, wipe_ptr=0.
  - Clear has priority over a simultaneous Ins_valid; that insert is not accepted, since Ins_ready was 0.
- Clear during WIPE restarts the wipe at wipe_ptr=0.
- Reset mid-wipe or mid-insert: the asynchronous reset wins immediately; the wipe restarts after release.
- Read port:
  - Latency is 1 cycle. On Rd_en, the next cycle gives Rd_x/Rd_y = mem[Rd_index].
  - Rd_valid = (Rd_index < Count) sampled at the request edge, and state==READY.
  - If the index is out of range or the block is Busy, Rd_valid=0 and Rd_x=Rd_y=0.
  - Without Rd_en, Rd_x, Rd_y and Rd_valid hold their values.
- Read and insert in the same cycle at Rd_index == Count: the read sees the old Count, so Rd_valid=0 (read-before-write).
- Memory: single write port (insert or wipe, mutually exclusive by state) and one synchronous read port; maps to block RAM.

Decomposition:
- Shared package astar_pkg holds:
  - COORD_W=8, DEPTH=400, IDX_W=9;
  - the state encodings WIPE and READY (8-bit, matching the search FSM style);
  - a node coordinate pair type used by the open list, closed list and search.
- One natural sub-module: closed_list_ram, a DEPTH x 2*COORD_W single-write, single-sync-read memory. The control FSM, counters and handshake stay in closed_list_writer.

Test Plan:
- Release reset, hold Ins_valid=1 -> Busy=1 and Ins_ready=0 for exactly 400 cycles, then Ins_ready=1; reading any index during the wipe gives Rd_valid=0.
- After the wipe, insert (3,5), (7,2), (0,0) on consecutive cycles -> Ins_ack pulses with Ins_index 0,1,2, Count=3; reading index 1 gives (7,2) with Rd_valid=1 one cycle later; reading index 3 gives Rd_valid=0 and (0,0).
- Insert 400 nodes (x=i%256, y=i/256) -> Full=1 and Ins_ready=0; one more Ins_valid -> Overflow=1, Count stays 400; reading index 399 gives (143,1).
- With Count=5, assert Clear together with Ins_valid -> no Ins_ack, Count=0, Overflow=0, Busy=1 for 400 cycles; reading index 0 afterwards gives Rd_valid=0.
- Pull Reset low mid-wipe (wipe_ptr=200) and mid-stream of inserts -> all outputs go to reset values immediately; the full 400-cycle wipe repeats after release.
- With Count=2, read index 2 in the same cycle as an accepted insert of (9,9) -> Rd_valid=0; reading index 2 next cycle -> (9,9), Rd_valid=1.
